pmem_writeback_buffer: RTL and testbench
========================================

// Module: pmem_writeback_buffer
// PURPOSE
//  Sits between the cache datapath/control pmem port and physical memory. Absorbs dirty-line evictions
//  into a small FIFO and acknowledges them quickly, and lets demand line fills bypass queued evictions.
//  Drains evictions to memory when no fill is pending. Keeps read-after-evict coherent by address matching.
// PARAMETERS
//  DEPTH  2  buffered eviction lines; power of 2, >=2
// PORTS
//  clk                 in   1    clock, all state on rising edge
//  reset_n             in   1    asynchronous active-low reset
//  cache_pmem_read     in   1    line fill request; held until cache_pmem_resp
//  cache_pmem_write    in   1    eviction request; held until cache_pmem_resp
//  cache_pmem_address  in   16   lc3b_word, line aligned ([3:0] ignored)
//  cache_pmem_wdata    in   128  lc3b_line eviction data
//  cache_pmem_rdata    out  128  lc3b_line fill data; valid while cache_pmem_resp=1
//  cache_pmem_resp     out  1    one-cycle registered acknowledge
//  pmem_read           out  1    memory read; held until pmem_resp
//  pmem_write          out  1    memory write; held until pmem_resp
//  pmem_address        out  16   memory line address, [3:0]=0
//  pmem_wdata          out  128  head entry data
//  pmem_rdata          in   128  memory read data; valid with pmem_resp
//  pmem_resp           in   1    memory acknowledge
//  wb_empty            out  1    1 when count==0 and FSM is IDLE
// BEHAVIOUR
//  Reset: count, pointers and FSM go to IDLE immediately. Buffered lines are discarded.
//   All outputs are 0, except wb_empty=1. pmem_read/pmem_write drop asynchronously, including mid-handshake.
//  FIFO: entries hold {addr[15:4], line}. Pointers are $clog2(DEPTH) bits and wrap. count is 0..DEPTH.
//  Enqueue: on the edge where cache_pmem_write=1, count<DEPTH and cache_pmem_resp=0. cache_pmem_resp=1 the next cycle.
//   Full: the write waits with no resp. Enqueue is allowed in any FSM state.
//   Enqueue and pop on the same edge leave count unchanged.
//   Same address twice: two entries, drained in order. Coalescing is not performed.
//  Read and write both asserted: write is served, read ignored until the write is acknowledged.
//  Match: a read line address equals a valid entry. The newest matching entry wins.
//  FSM IDLE/RD/WR; pmem_read=(RD), pmem_write=(WR), both registered.
//   IDLE: read pending and unforwarded, and (no match or WB_FORWARD_EN) -> RD.
//         Else read pending with match (macro off) -> WR.
//         Else count>0 -> WR.
//   RD: pmem_address=read addr. On pmem_resp, latch pmem_rdata, cache_pmem_resp=1 the next cycle, -> IDLE.
//   WR: pmem_address/pmem_wdata=head. On pmem_resp, pop, -> IDLE.
//  A started WR is never aborted; a read arriving during WR waits for it.
//  Read miss latency: pmem_read asserts 1 cycle after the request is sampled in IDLE.
//   cache_pmem_resp comes 1 cycle after pmem_resp.
//  Read hit with no match, and count==0 or count>0: reads take priority over draining.
// CONFIGURATION
//  WB_FORWARD_EN defined: a matching read is answered from the newest matching entry.
//   cache_pmem_resp=1 one cycle after sampling; no memory access; the FSM stays IDLE.
//  Undefined: a matching read forces drains (WR) until no entry matches, then proceeds to RD.
// STRUCTURE
//  lc3b_types gains lc3b_line_addr (logic [11:0]) and the constant WB_DEPTH=2.
//  One sub-module: wb_match (combinational). Inputs: entry addrs, valid mask, head pointer, read addr.
//   Outputs: hit, newest hit index.
//  FIFO storage, pointers and FSM are inline.
// TESTING
//  1 Write 0x1230/L0 with an idle buffer -> resp next cycle, then pmem_write addr 0x1230 data L0.
//    After pmem_resp, wb_empty=1.
//  2 Fill two entries, stall pmem_resp, issue a third write -> no resp until the first pop.
//    Then resp; count stays 2.
//  3 Entry 0x4000 queued, not yet in WR; read 0x8000 -> pmem_read 0x8000 before any pmem_write.
//    Data returned, then the drain follows.
//  4 Entries 0x2000/A then 0x2000/B; read 0x2008. Macro on: rdata=B in 1 cycle, no pmem_read.
//    Macro off: two pmem_writes (A, B), then pmem_read 0x2000.
//  5 Pointer wrap: 5 write/drain cycles with DEPTH=2 -> addresses leave in issue order; count never exceeds 2.
//  6 reset_n low during WR -> pmem_write=0 asynchronously; count=0, wb_empty=1.
//    After release, a read behaves as in scenario 3.

Source files
------------

// File: rtl/pmem_writeback_buffer_pkg.sv
// Shared types for the pmem writeback buffer: LC-3b word/line types, line address and FSM states.
package pmem_writeback_buffer_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_addr;

  localparam int WB_DEPTH = 2;

  typedef enum logic [1:0] {WB_IDLE, WB_RD, WB_WR} wb_state_e;
endpackage

// File: rtl/pmem_writeback_buffer_if.sv
// Line-granular pmem port; used on the cache side (buffer is slave) and memory side (buffer is master).
interface pmem_writeback_buffer_if;
  import pmem_writeback_buffer_pkg::*;
  logic     read;
  logic     write;
  lc3b_word address;
  lc3b_line wdata;
  lc3b_line rdata;
  logic     resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_writeback_buffer_wb_match.sv
// Read-address lookup over the eviction FIFO; reports whether any valid entry matches and the newest one.
module wb_match
  import pmem_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  lc3b_line_addr    entry_addr [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  lc3b_line_addr    rd_addr,
  output logic             hit,
  output logic [PW-1:0]    hit_idx
);
  // Walk oldest to newest so the last match seen is the newest one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[head + PW'(k)] && entry_addr[head + PW'(k)] == rd_addr) begin
        hit     = 1'b1;
        hit_idx = head + PW'(k);
      end
    end
  end
endmodule

// File: rtl/pmem_writeback_buffer.sv
// Eviction FIFO between cache and memory; fills bypass queued evictions, address match keeps reads coherent.
// Optional macro WB_FORWARD_EN: matching reads are answered from the buffer instead of forcing drains.
module pmem_writeback_buffer
  import pmem_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  pmem_writeback_buffer_if.slave         cache,
  pmem_writeback_buffer_if.master        pmem,
  output logic                           wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  lc3b_line_addr    entry_addr [DEPTH];
  lc3b_line         entry_line [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  wb_state_e        state, state_nxt;
  logic             cache_resp_q;
  lc3b_line         rdata_q;
  lc3b_line_addr    rd_addr_q;
  logic             hit;
  logic [PW-1:0]    hit_idx;
  logic             rd_pend, enq, pop, rd_done, fwd;

  // A request is considered only while its acknowledge is not already being presented.
  assign rd_pend = cache.read && !cache.write && !cache_resp_q;
  assign enq     = cache.write && !cache_resp_q && (count < CW'(DEPTH));
  assign pop     = (state == WB_WR) && pmem.resp;
  assign rd_done = (state == WB_RD) && pmem.resp;
`ifdef WB_FORWARD_EN
  assign fwd     = (state == WB_IDLE) && rd_pend && hit;
`else
  assign fwd     = 1'b0;
`endif

  always_comb begin
    valid = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < count) valid[head + PW'(k)] = 1'b1;
  end

  wb_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
    .entry_addr (entry_addr),
    .valid      (valid),
    .head       (head),
    .rd_addr    (cache.address[15:4]),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  // Line storage is discarded on reset through the pointers, so it needs no reset itself.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr[tail] <= cache.address[15:4];
      entry_line[tail] <= cache.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (enq && !pop)      count <= count + 1'b1;
      else if (pop && !enq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_resp_q <= 1'b0;
      rdata_q      <= '0;
      rd_addr_q    <= '0;
    end else begin
      cache_resp_q <= enq || rd_done || fwd;
      if (rd_done)  rdata_q <= pmem.rdata;
      else if (fwd) rdata_q <= entry_line[hit_idx];
      if (state == WB_IDLE && state_nxt == WB_RD) rd_addr_q <= cache.address[15:4];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE: begin
        if (rd_pend) begin
`ifdef WB_FORWARD_EN
          state_nxt = hit ? WB_IDLE : WB_RD;
`else
          // A matching read must see memory only after every matching entry has drained.
          state_nxt = hit ? WB_WR : WB_RD;
`endif
        end else if (count != '0) begin
          state_nxt = WB_WR;
        end
      end
      WB_RD:   if (pmem.resp) state_nxt = WB_IDLE;
      WB_WR:   if (pmem.resp) state_nxt = WB_IDLE;
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_comb begin
    pmem.read    = (state == WB_RD);
    pmem.write   = (state == WB_WR);
    pmem.address = '0;
    pmem.wdata   = '0;
    case (state)
      WB_RD: pmem.address = {rd_addr_q, 4'h0};
      WB_WR: begin
        pmem.address = {entry_addr[head], 4'h0};
        pmem.wdata   = entry_line[head];
      end
      default: ;
    endcase
  end

  assign cache.resp  = cache_resp_q;
  assign cache.rdata = rdata_q;
  assign wb_empty    = (count == '0) && (state == WB_IDLE);
endmodule

// File: tb/tb_pmem_writeback_buffer.sv
// Directed bench for pmem_writeback_buffer: expected memory traffic and cache responses go into queues,
// monitors on both ports pop and compare. Build with WB_FORWARD_EN to exercise the forwarding variant.
module tb_pmem_writeback_buffer;
  import pmem_writeback_buffer_pkg::*;

  typedef struct { logic wr; lc3b_word addr; lc3b_line data; } mexp_t;
  typedef struct { logic rd; lc3b_line data; } cexp_t;

  localparam lc3b_line L0  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam lc3b_line LA  = {4{32'hA0A0_0001}};
  localparam lc3b_line LB  = {4{32'hB0B0_0002}};
  localparam lc3b_line LP  = {4{32'h7777_0003}};
  localparam lc3b_line L4  = {4{32'h4444_0004}};
  localparam lc3b_line R8000 = {8{16'hDA5A}};
  localparam lc3b_line R2000 = {8{16'h7A5A}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wb_empty;
  logic mem_stall = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   max_cnt = 0;
  int   cyc;
  logic early;

  mexp_t mexp_q[$];
  cexp_t cexp_q[$];

  pmem_writeback_buffer_if cache_bus ();
  pmem_writeback_buffer_if mem_bus ();

  pmem_writeback_buffer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cache    (cache_bus),
    .pmem     (mem_bus),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model and memory-side monitor: one-cycle acknowledge unless stalled.
  always @(negedge clk) begin : mem_model
    mexp_t e;
    if (mem_bus.resp) begin
      mem_bus.resp = 1'b0;
    end else if ((mem_bus.read || mem_bus.write) && !mem_stall) begin
      mem_bus.resp  = 1'b1;
      mem_bus.rdata = {8{mem_bus.address ^ 16'h5A5A}};
      checks++;
      if (mexp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_unexpected wr=%0b addr=%0h required=no access", mem_bus.write, mem_bus.address);
      end else begin
        e = mexp_q.pop_front();
        if (e.wr !== mem_bus.write || e.addr !== mem_bus.address || (e.wr && e.data !== mem_bus.wdata)) begin
          failures++;
          $display("FAIL mem_txn actual wr=%0b addr=%0h data=%0h required wr=%0b addr=%0h data=%0h",
                   mem_bus.write, mem_bus.address, mem_bus.wdata, e.wr, e.addr, e.data);
        end
      end
    end
  end

  // Cache-side monitor: every acknowledge must be expected; reads carry data.
  always @(negedge clk) begin : cache_mon
    cexp_t c;
    if (dut.count > max_cnt) max_cnt = dut.count;
    if (cache_bus.resp) begin
      checks++;
      if (cexp_q.size() == 0) begin
        failures++;
        $display("FAIL cache_unexpected_resp actual=1 required=0");
      end else begin
        c = cexp_q.pop_front();
        if (c.rd && cache_bus.rdata !== c.data) begin
          failures++;
          $display("FAIL cache_rdata actual=%0h required=%0h", cache_bus.rdata, c.data);
        end
      end
    end
  end

  task automatic cache_write(input lc3b_word a, input lc3b_line d, output int n);
    cexp_q.push_back('{1'b0, '0});
    cache_bus.write = 1'b1; cache_bus.address = a; cache_bus.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!cache_bus.resp && n < 100);
    if (!cache_bus.resp) begin
      failures++;
      $display("FAIL write_timeout addr=%0h actual=no resp required=resp", a);
    end
    cache_bus.write = 1'b0;
  endtask

  task automatic cache_read(input lc3b_word a, input lc3b_line exp_d);
    int n = 0;
    cexp_q.push_back('{1'b1, exp_d});
    cache_bus.read = 1'b1; cache_bus.address = a;
    do begin @(negedge clk); n++; end while (!cache_bus.resp && n < 100);
    if (!cache_bus.resp) begin
      failures++;
      $display("FAIL read_timeout addr=%0h actual=no resp required=resp", a);
    end
    cache_bus.read = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!(wb_empty && mexp_q.size() == 0) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!wb_empty || mexp_q.size() != 0) begin
      failures++;
      $display("FAIL %s actual wb_empty=%0b pending=%0d required wb_empty=1 pending=0",
               name, wb_empty, mexp_q.size());
    end
  endtask

  initial begin
    cache_bus.read = 1'b0; cache_bus.write = 1'b0;
    cache_bus.address = '0; cache_bus.wdata = '0;
    mem_bus.resp = 1'b0; mem_bus.rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb_empty", 128'(wb_empty), 128'd1);
    chk("rst_pmem_rw", {mem_bus.read, mem_bus.write}, 128'd0);
    chk("rst_cache_resp", 128'(cache_bus.resp), 128'd0);
    chk("rst_rdata", cache_bus.rdata, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single eviction, ack next cycle, drains to memory
    mexp_q.push_back('{1'b1, 16'h1230, L0});
    cache_write(16'h1230, L0, cyc);
    chk("t1_resp_latency", 128'(cyc), 128'd1);
    wait_empty("t1_drain");

    // 2: full buffer holds the third write off until the first pop
    mem_stall = 1'b1;
    mexp_q.push_back('{1'b1, 16'h3000, {4{32'h3000_0001}}});
    mexp_q.push_back('{1'b1, 16'h3010, {4{32'h3000_0002}}});
    mexp_q.push_back('{1'b1, 16'h3020, {4{32'h3000_0003}}});
    cache_write(16'h3000, {4{32'h3000_0001}}, cyc);
    cache_write(16'h3010, {4{32'h3000_0002}}, cyc);
    early = 1'b0;
    fork
      cache_write(16'h3020, {4{32'h3000_0003}}, cyc);
      begin
        repeat (4) begin @(negedge clk); if (cache_bus.resp) early = 1'b1; end
        chk("t2_full_no_resp", 128'(early), 128'd0);
        chk("t2_full_count", 128'(dut.count), 128'd2);
        mem_stall = 1'b0;
      end
    join
    chk("t2_count_after_enq", 128'(dut.count), 128'd2);
    wait_empty("t2_drain");

    // 3: read miss bypasses a queued eviction
    mem_stall = 1'b1;
    mexp_q.push_back('{1'b1, 16'h7000, LP});
    cache_write(16'h7000, LP, cyc);
    mexp_q.push_back('{1'b0, 16'h8000, '0});
    mexp_q.push_back('{1'b1, 16'h4000, L4});
    cache_write(16'h4000, L4, cyc);
    fork
      cache_read(16'h8000, R8000);
      begin repeat (3) @(negedge clk); mem_stall = 1'b0; end
    join
    wait_empty("t3_drain");

    // 4: read hitting two same-address entries
    mem_stall = 1'b1;
    mexp_q.push_back('{1'b1, 16'h2000, LA});
    mexp_q.push_back('{1'b1, 16'h2000, LB});
    cache_write(16'h2000, LA, cyc);
    cache_write(16'h2000, LB, cyc);
`ifdef WB_FORWARD_EN
    fork
      cache_read(16'h2008, LB);
      begin repeat (2) @(negedge clk); mem_stall = 1'b0; end
    join
`else
    mexp_q.push_back('{1'b0, 16'h2000, '0});
    fork
      cache_read(16'h2008, R2000);
      begin repeat (2) @(negedge clk); mem_stall = 1'b0; end
    join
`endif
    wait_empty("t4_drain");

    // 5: pointer wrap over five write/drain cycles
    for (int i = 0; i < 5; i++) begin
      mexp_q.push_back('{1'b1, 16'h5000 + 16'(i * 16), {4{32'h5500_0000 + i}}});
      cache_write(16'h5000 + 16'(i * 16), {4{32'h5500_0000 + i}}, cyc);
    end
    wait_empty("t5_drain");
    chk("t5_max_count_le2", 128'(max_cnt <= 2), 128'd1);

    // 6: asynchronous reset in the middle of a memory write
    mem_stall = 1'b1;
    cache_write(16'h6000, {4{32'h6666_0006}}, cyc);
    @(negedge clk);
    chk("t6_in_wr", 128'(mem_bus.write), 128'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_pmem_write", 128'(mem_bus.write), 128'd0);
    chk("t6_count", 128'(dut.count), 128'd0);
    chk("t6_wb_empty", 128'(wb_empty), 128'd1);
    @(negedge clk);
    reset_n = 1'b1;
    mem_stall = 1'b0;
    @(negedge clk);
    mexp_q.push_back('{1'b0, 16'h8000, '0});
    cexp_q.push_back('{1'b1, R8000});
    cache_bus.read = 1'b1; cache_bus.address = 16'h8005;
    @(negedge clk);
    chk("t6_rd_latency", {mem_bus.read, mem_bus.address}, {1'b1, 16'h8000});
    @(negedge clk);
    chk("t6_resp_after_pmem_resp", 128'(cache_bus.resp), 128'd1);
    cache_bus.read = 1'b0;
    wait_empty("t6_idle");

    repeat (2) @(negedge clk);
    chk("cache_exp_drained", 128'(cexp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
